// File: rtl/serial_add_sequencer_if.sv
// ----------------------------------------------------------------------------
// serial_add_sequencer_if
//   Operand/result bundle for the nibble-serial adder/subtractor.
//
//   Request side (master drives):
//     Start     level-sensitive operation request
//     Sub       0 = A+B, 1 = A-B
//     A, B      W-bit operands
//   Result side (slave drives):
//     Busy      high while nibbles are being processed
//     Done      high while Sum/C_out/Overflow hold a valid result
//     Sum       W-bit result
//     C_out     carry out of the MSB nibble (for Sub=1, 1 = no borrow)
//     Overflow  two's-complement signed overflow
//     state_dbg current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
//
//   Handshake: a request is accepted on a rising edge where Start=1 and the
//   sequencer is idle. The result is valid while Done=1 and is held there
//   until Start is seen low; a new request needs Start low, then high again.
// ----------------------------------------------------------------------------
interface serial_add_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         Start;
    logic         Sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Sum;
    logic         C_out;
    logic         Overflow;
    logic [1:0]   state_dbg;

    modport master (
        output Start, Sub, A, B,
        input  Busy, Done, Sum, C_out, Overflow, state_dbg
    );

    modport slave (
        input  Start, Sub, A, B,
        output Busy, Done, Sum, C_out, Overflow, state_dbg
    );
endinterface

// File: rtl/serial_add_sequencer.sv
// ----------------------------------------------------------------------------
// serial_add_sequencer
//   Adds or subtracts two W-bit operands (W = 4*NIBBLES) using a single 4-bit
//   add slice, one nibble per clock, LSB nibble first.
//
//   Ports:
//     Clk    rising-edge clock
//     Reset  synchronous active-high reset
//     bus    serial_add_sequencer_if.slave (Start/Sub/A/B in,
//            Busy/Done/Sum/C_out/Overflow/state_dbg out)
//
//   Timing: the edge that accepts Start latches the operands, the next
//   NIBBLES edges process one nibble each, and the last of them moves to
//   DONE. Busy is therefore high for NIBBLES cycles, then Done rises.
// ----------------------------------------------------------------------------
module serial_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    serial_add_sequencer_if.slave bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;      // already inverted for subtraction
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     sum_r;
    logic             c_out_r;
    logic             ovf_r;

    // The one shared 4-bit add slice, fed by the nibble selected by idx.
    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_sum;
    logic       slice_co;

    always_comb begin
        slice_a = op_a[{idx, 2'b00} +: 4];
        slice_b = op_b[{idx, 2'b00} +: 4];
        {slice_co, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, carry};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        // Subtraction is A + ~B + 1: invert B here and seed
                        // the carry with Sub.
                        op_a  <= bus.A;
                        op_b  <= bus.Sub ? ~bus.B : bus.B;
                        carry <= bus.Sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r[{idx, 2'b00} +: 4] <= slice_sum;
                    carry <= slice_co;
                    if (idx == LAST_IDX) begin
                        idx     <= '0;
                        c_out_r <= slice_co;
                        // Same-sign operands whose result sign differs.
                        ovf_r   <= (op_a[W-1] == op_b[W-1]) &&
                                   (slice_sum[3] != op_a[W-1]);
                        state   <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // Leaving DONE only on Start low keeps a held Start from
                    // relaunching.
                    if (!bus.Start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy      = (state == RUN);
    assign bus.Done      = (state == DONE);
    assign bus.Sum       = sum_r;
    assign bus.C_out     = c_out_r;
    assign bus.Overflow  = ovf_r;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// ----------------------------------------------------------------------------
// tb_serial_add_sequencer
//   Directed bench for serial_add_sequencer (NIBBLES = 4). Inputs change and
//   outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_serial_add_sequencer;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic Clk;
    logic Reset;

    serial_add_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

    serial_add_sequencer #(.NIBBLES(NIBBLES)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (entered and left just after a falling edge)
    // ------------------------------------------------------------------
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    // Launch one operation and check it through to Done.
    //   hold_start: keep Start high after launch
    //   scramble  : change A/B/Sub on every RUN cycle
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] exp_sum,
                          input logic exp_c, input logic exp_v,
                          input logic hold_start, input logic scramble);
        logic [W-1:0] exp_s;
        exp_q.push_back(exp_sum);
        bus.A     = a;
        bus.B     = b;
        bus.Sub   = sub;
        bus.Start = 1'b1;
        for (int i = 0; i < NIBBLES; i++) begin
            @(negedge Clk);
            if (!hold_start) bus.Start = 1'b0;
            if (scramble) begin
                bus.A   = W'($urandom_range(0, 16'hFFFF));
                bus.B   = W'($urandom_range(0, 16'hFFFF));
                bus.Sub = ~bus.Sub;
            end
            check({tag, " busy"}, 32'(bus.Busy), 32'd1);
            if (i == 0) check({tag, " done_low"}, 32'(bus.Done), 32'd0);
        end
        @(negedge Clk);
        exp_s = exp_q.pop_front();
        check({tag, " done"},     32'(bus.Done),     32'd1);
        check({tag, " busy_end"}, 32'(bus.Busy),     32'd0);
        check({tag, " sum"},      32'(bus.Sum),      32'(exp_s));
        check({tag, " c_out"},    32'(bus.C_out),    32'(exp_c));
        check({tag, " ovf"},      32'(bus.Overflow), 32'(exp_v));
    endtask

    // Drop Start and confirm return to idle with the result retained.
    task automatic release_start(input string tag, input logic [W-1:0] exp_sum);
        bus.Start = 1'b0;
        @(negedge Clk);
        check({tag, " idle_done"}, 32'(bus.Done), 32'd0);
        check({tag, " idle_busy"}, 32'(bus.Busy), 32'd0);
        check({tag, " idle_sum"},  32'(bus.Sum),  32'(exp_sum));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.Sub   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        idle_cycles(3);
        check("rst busy",  32'(bus.Busy),      32'd0);
        check("rst done",  32'(bus.Done),      32'd0);
        check("rst sum",   32'(bus.Sum),       32'd0);
        check("rst c_out", 32'(bus.C_out),     32'd0);
        check("rst ovf",   32'(bus.Overflow),  32'd0);
        check("rst state", 32'(bus.state_dbg), 32'd0);
        Reset = 1'b0;
        idle_cycles(2);
        check("idle hold", 32'(bus.Busy), 32'd0);

        // Basic additions and subtractions
        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        release_start("add_basic", 16'h5555);
        run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        release_start("add_wrap", 16'h0000);
        run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        release_start("add_ovf", 16'h8000);
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        release_start("sub_neg", 16'hFFFE);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        release_start("sub_ovf", 16'h7FFF);

        // Inputs churn during RUN: latched operands (0x0F0F + 0x1111) win
        run_op("scramble",  16'h0F0F, 16'h1111, 1'b0, 16'h2020, 1'b0, 1'b0, 1'b0, 1'b1);
        release_start("scramble", 16'h2020);

        // Start held high: one operation only, Done stays up
        run_op("hold",      16'h1000, 16'h0234, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.A = 16'h0001;
        bus.B = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            check("hold done", 32'(bus.Done), 32'd1);
            check("hold busy", 32'(bus.Busy), 32'd0);
            check("hold sum",  32'(bus.Sum),  32'h1234);
        end
        release_start("hold", 16'h1234);
        run_op("relaunch",  16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        release_start("relaunch", 16'h0000);

        // Reset on the second RUN cycle aborts the operation
        bus.A     = 16'h3333;
        bus.B     = 16'h1111;
        bus.Sub   = 1'b0;
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        check("abort busy1", 32'(bus.Busy), 32'd1);
        @(negedge Clk);
        check("abort busy2", 32'(bus.Busy), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        check("abort busy",  32'(bus.Busy),     32'd0);
        check("abort done",  32'(bus.Done),     32'd0);
        check("abort sum",   32'(bus.Sum),      32'd0);
        check("abort c_out", 32'(bus.C_out),    32'd0);
        check("abort ovf",   32'(bus.Overflow), 32'd0);
        Reset = 1'b0;
        // Start present on the very first edge after release
        run_op("post_rst",  16'h0003, 16'h0004, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        release_start("post_rst", 16'hFFFF);

        check("exp_q empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
